// File: rtl/regs_file.sv
// Integer register file for RV64: 2 comb read ports, 1 write port, serial dump engine.
// Latency: reads zero-cycle with write-first bypass; dump beat registered, 32 beats + 1 done cycle.
// Backpressure: dump beat holds idx/data while dump_ready_i is low; reads/writes never stall. Optional: REGS_DIFFTEST_EN.
module regs_file #(
    parameter int XLEN    = 64,
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic [XLEN-1:0]   rs1_data_o,
    output logic [XLEN-1:0]   rs2_data_o,
    input  logic [ADDR_W-1:0] reg_waddr_i,
    input  logic [XLEN-1:0]   reg_wdata_i,
    input  logic              reg_wen_i,
    input  logic              dump_req_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [ADDR_W-1:0] dump_idx_o,
    output logic [XLEN-1:0]   dump_data_o,
    output logic              dump_busy_o,
    output logic              dump_done_o
`ifdef REGS_DIFFTEST_EN
    ,
    output logic [REG_NUM*XLEN-1:0] regs_flat_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

    logic [XLEN-1:0]   regs_q [REG_NUM];
    logic [XLEN-1:0]   regs_d [REG_NUM];
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [XLEN-1:0]   data_q, data_d;

    // x0 is hardwired; a same-cycle write to the addressed register wins over storage.
    function automatic logic [XLEN-1:0] bypass_rd(input logic [ADDR_W-1:0] addr);
        if (addr == '0) begin
            return '0;
        end else if (reg_wen_i && (reg_waddr_i == addr)) begin
            return reg_wdata_i;
        end else begin
            return regs_q[addr];
        end
    endfunction

    assign rs1_data_o = bypass_rd(rs1_addr_i);
    assign rs2_data_o = bypass_rd(rs2_addr_i);

    always_comb begin
        regs_d = regs_q;
        if (reg_wen_i && (reg_waddr_i != '0)) begin
            regs_d[reg_waddr_i] = reg_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        data_d       = data_q;
        dump_valid_o = 1'b0;
        dump_done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dump_req_i) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                    data_d  = '0;
                end
            end
            ST_SEND: begin
                dump_valid_o = 1'b1;
                if (dump_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        // Snapshot the next beat now so later writes cannot disturb it.
                        idx_d  = idx_q + ADDR_W'(1);
                        data_d = bypass_rd(idx_q + ADDR_W'(1));
                    end
                end
            end
            ST_DONE: begin
                dump_done_o = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    assign dump_idx_o  = idx_q;
    assign dump_data_o = data_q;
    assign dump_busy_o = (state_q != ST_IDLE);

`ifdef REGS_DIFFTEST_EN
    for (genvar g = 0; g < REG_NUM; g++) begin : g_flat
        assign regs_flat_o[g*XLEN +: XLEN] = regs_q[g];
    end
`endif

endmodule
